in_reg_filter: RTL and testbench

//  Registered input stage fed by IN_BUFF.Q; sits between the input buffer and the fabric (IQZ path).

---
 rtl/in_reg_filter.sv | 104 ++++++++++
 tb/tb_in_reg_filter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/in_reg_filter.sv
// Registered pad input stage: synchroniser, glitch filter, hold/bypass, optional edge pulses.
// Edge pulse logic is built only when IN_REG_FILTER_EDGE_EN is defined.
module in_reg_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILT_CNT_W  = 3,
  parameter int   FILT_LEN    = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic IQC,
  input  logic QRT,
  input  logic dataIn,
  input  logic hold,
  input  logic sel,
  output logic dataOut,
  output logic riseOut,
  output logic fallOut
);

  localparam logic [FILT_CNT_W-1:0] CNT_ZERO = FILT_CNT_W'(0);
  localparam logic [FILT_CNT_W-1:0] CNT_ONE  = FILT_CNT_W'(1);
  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sy_s;

  assign sy_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain; keeps shifting while hold is asserted.
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], dataIn};
    end
  end

  // Filter next state: a level is accepted after FILT_LEN consecutive differing samples.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (hold) begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
    end else if (sy_s == filt_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sy_s;
      cnt_d  = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Filter state registers.
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      cnt_q  <= CNT_ZERO;
      filt_q <= RST_VAL;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign dataOut = sel ? filt_q : dataIn;

`ifdef IN_REG_FILTER_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Pulses coincide with the first cycle the filtered level shows its new value.
  always_comb begin
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (hold) begin
      rise_d = 1'b0;
      fall_d = 1'b0;
    end else begin
      rise_d = ~filt_q &  filt_d;
      fall_d =  filt_q & ~filt_d;
    end
  end

  // Edge pulse registers.
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign riseOut = rise_q;
  assign fallOut = fall_q;
`else
  assign riseOut = 1'b0;
  assign fallOut = 1'b0;
`endif

endmodule

// File: tb/tb_in_reg_filter.sv
// Scoreboard bench for in_reg_filter: instance A uses defaults, instance B uses
// SYNC_STAGES=3, FILT_LEN=1, RST_VAL=1. Edge expectations follow IN_REG_FILTER_EDGE_EN.
module tb_in_reg_filter;

`ifdef IN_REG_FILTER_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_din, a_hold, a_sel, a_out, a_rise, a_fall;
  logic b_rst, b_din, b_hold, b_sel, b_out, b_rise, b_fall;

  in_reg_filter u_a (
    .IQC(clk), .QRT(a_rst), .dataIn(a_din), .hold(a_hold), .sel(a_sel),
    .dataOut(a_out), .riseOut(a_rise), .fallOut(a_fall)
  );

  in_reg_filter #(.SYNC_STAGES(3), .FILT_CNT_W(3), .FILT_LEN(1), .RST_VAL(1'b1)) u_b (
    .IQC(clk), .QRT(b_rst), .dataIn(b_din), .hold(b_hold), .sel(b_sel),
    .dataOut(b_out), .riseOut(b_rise), .fallOut(b_fall)
  );

  typedef struct {
    bit    is_b;
    logic  eo;
    logic  er;
    logic  ef;
    string name;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  logic m_o, m_r, m_f;
  int   checks = 0;
  int   errors = 0;

  task automatic push(input bit is_b, input logic eo, input logic er, input logic ef,
                      input string name);
    exp_t e;
    e.is_b = is_b;
    e.eo   = eo;
    e.er   = er & EDGE_EN;
    e.ef   = ef & EDGE_EN;
    e.name = name;
    sb_q.push_back(e);
  endtask

  // One clock on the selected instance; expectation is the state after that edge.
  task automatic cyc(input bit is_b, input logic din, input logic hld,
                     input logic eo, input logic er, input logic ef, input string name);
    if (is_b) begin
      b_din = din; b_hold = hld;
    end else begin
      a_din = din; a_hold = hld;
    end
    @(posedge clk);
    #1;
    push(is_b, eo, er, ef, name);
    @(negedge clk);
    #1;
  endtask

  // Check current outputs without an intervening active edge.
  task automatic chk_now(input bit is_b, input logic eo, input string name);
    push(is_b, eo, 1'b0, 1'b0, name);
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops and compares on every falling edge that has a pending expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      m_o = m_e.is_b ? b_out  : a_out;
      m_r = m_e.is_b ? b_rise : a_rise;
      m_f = m_e.is_b ? b_fall : a_fall;
      checks++;
      if ({m_o, m_r, m_f} !== {m_e.eo, m_e.er, m_e.ef}) begin
        errors++;
        $display("FAIL %s: got out=%0b rise=%0b fall=%0b, expected out=%0b rise=%0b fall=%0b",
                 m_e.name, m_o, m_r, m_f, m_e.eo, m_e.er, m_e.ef);
      end
    end
  end

  initial begin
    a_rst = 1'b1; a_din = 1'b1; a_hold = 1'b0; a_sel = 1'b1;
    b_rst = 1'b1; b_din = 1'b1; b_hold = 1'b0; b_sel = 1'b1;

    // Reset state and first acceptance latency
    chk_now(1'b0, 1'b0, "a_reset");
    chk_now(1'b1, 1'b1, "b_reset_rstval1");
    a_rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "a_latency_wait");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "a_latency_edge6_rise");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "a_rise_one_cycle");

    // Low glitch of 3 samples is rejected
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "a_glitch3_low");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "a_glitch3_recover");

    // Hold freezes count at 2; two edges after release the new level lands
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "a_pre_hold");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "a_during_hold");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "a_release_edge1");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "a_release_edge2_fall");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "a_fall_one_cycle");

    // Interrupted run restarts the count
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "a_restart_high");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "a_restart_dip");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "a_restart_wait");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "a_restart_accept");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "a_restart_settled");

    // Bypass follows dataIn; registered path returns filtered level
    a_sel = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "a_bypass0");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "a_bypass1");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "a_bypass0b");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "a_bypass1b");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "a_bypass0c");
    a_sel = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "a_sel_filtered");

    // Async reset mid-count, then full latency from a cleared counter
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "a_midcount");
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    chk_now(1'b0, 1'b0, "a_async_reset");
    a_rst = 1'b0;
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "a_post_rst_hold");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "a_post_rst_count");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "a_post_rst_accept");

    // Instance B: three sync stages, single-sample acceptance, reset value 1
    b_rst = 1'b0;
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "b_no_pulse_after_rst");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "b_fall_wait");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b_fall_accept");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b_fall_settled");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "b_rise_wait");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "b_rise_accept");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "b_rise_settled");

    repeat (3) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
